bomb_controller: RTL

//   Per-player bomb placement, fuse timing, three-phase explosion sequencing and blast/player

---
 rtl/bomb_controller.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bomb_controller.sv
// bomb_controller: per-player bomb placement, fuse timing, three-phase explosion
// sequencing and blast/player overlap detection.
//
// Ports
//   Clk, Reset_n            system clock, asynchronous active-low reset
//   frame_tick              one-Clk pulse per video frame
//   keycode[7:0]            current keycode (8'h19 places P1 bomb, 8'h13 places P2 bomb)
//   game_state[4:0]         5'b11000 play, 5'b00000/5'b00001 title, anything else freezes
//   p1_x/p1_y, p2_x/p2_y    player tile positions
//   b1_x/b1_y, b2_x/b2_y    latched bomb tiles
//   b1_phase, b2_phase      0 idle, 1 fuse, 2..4 explosion phases
//   p1die, p2die            sticky "caught in a blast" flags
//
// bomb_fsm states
//   state  | meaning
//   S_IDLE | no bomb owned
//   S_FUSE | bomb placed, counting FUSE_FRAMES frames
//   S_EXP1 | first explosion phase, EXP_FRAMES frames
//   S_EXP2 | second explosion phase, EXP_FRAMES frames
//   S_EXP3 | third explosion phase, EXP_FRAMES frames, then back to idle

module bomb_fsm #(
    parameter int COORD_W     = 4,
    parameter int FUSE_FRAMES = 120,
    parameter int EXP_FRAMES  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_play,
    input  logic               i_title,
    input  logic               i_tick,
    input  logic               i_req,
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    output logic [COORD_W-1:0] o_bx,
    output logic [COORD_W-1:0] o_by,
    output logic [2:0]         o_phase
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FUSE = 3'd1,
        S_EXP1 = 3'd2,
        S_EXP2 = 3'd3,
        S_EXP3 = 3'd4
    } state_t;

    localparam logic [7:0] FUSE_TC = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] EXP_TC  = 8'(EXP_FRAMES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_cnt;
    logic [7:0]         w_next_cnt;
    logic               w_latch;
    logic [7:0]         w_tc;
    state_t             w_succ;
    logic [COORD_W-1:0] r_bx;
    logic [COORD_W-1:0] r_by;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bx    <= '0;
            r_by    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_latch) begin
                r_bx <= i_px;
                r_by <= i_py;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_latch      = 1'b0;
        w_tc         = (r_state == S_FUSE) ? FUSE_TC : EXP_TC;
        w_succ       = S_IDLE;
        case (r_state)
            S_FUSE:  w_succ = S_EXP1;
            S_EXP1:  w_succ = S_EXP2;
            S_EXP2:  w_succ = S_EXP3;
            default: w_succ = S_IDLE;
        endcase

        if (i_title) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
        end else if (i_play) begin
            case (r_state)
                S_IDLE: begin
                    w_next_cnt = '0;
                    if (i_req) begin
                        w_next_state = S_FUSE;
                        w_latch      = 1'b1;
                    end
                end
                S_FUSE, S_EXP1, S_EXP2, S_EXP3: begin
                    if (i_tick) begin
                        // Terminal compare precedes the increment, so the counter never wraps.
                        if (r_cnt == w_tc) begin
                            w_next_state = w_succ;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_cnt = r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    assign o_bx    = r_bx;
    assign o_by    = r_by;
    assign o_phase = r_state;

endmodule

module bomb_controller #(
    parameter int COORD_W     = 4,
    parameter int FUSE_FRAMES = 120,
    parameter int EXP_FRAMES  = 16,
    parameter int BLAST_R     = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic [7:0]         keycode,
    input  logic [4:0]         game_state,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    output logic [COORD_W-1:0] b1_x,
    output logic [COORD_W-1:0] b1_y,
    output logic [COORD_W-1:0] b2_x,
    output logic [COORD_W-1:0] b2_y,
    output logic [2:0]         b1_phase,
    output logic [2:0]         b2_phase,
    output logic               p1die,
    output logic               p2die
);

    localparam logic [7:0]   KEY_P1 = 8'h19;
    localparam logic [7:0]   KEY_P2 = 8'h13;
    localparam logic [COORD_W:0] REACH = (COORD_W + 1)'(BLAST_R);

    logic [7:0] r_prev_key;
    logic       r_p1die;
    logic       r_p2die;
    logic       w_play;
    logic       w_title;
    logic       w_req1;
    logic       w_req2;
    logic       w_hit1;
    logic       w_hit2;

    function automatic logic [COORD_W-1:0] f_absdiff(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Cross-shaped blast, only while the bomb is in one of the explosion phases.
    function automatic logic f_covered(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y,
                                       input logic [COORD_W-1:0] bx,
                                       input logic [COORD_W-1:0] by,
                                       input logic [2:0]         phase);
        logic exploding;
        logic row_hit;
        logic col_hit;
        exploding = (phase >= 3'd2) && (phase <= 3'd4);
        row_hit   = (y == by) && ({1'b0, f_absdiff(x, bx)} <= REACH);
        col_hit   = (x == bx) && ({1'b0, f_absdiff(y, by)} <= REACH);
        return exploding && (row_hit || col_hit);
    endfunction

    assign w_play  = (game_state == 5'b11000);
    assign w_title = (game_state == 5'b00000) || (game_state == 5'b00001);
    assign w_req1  = (keycode == KEY_P1) && (r_prev_key != KEY_P1);
    assign w_req2  = (keycode == KEY_P2) && (r_prev_key != KEY_P2);

    bomb_fsm #(
        .COORD_W    (COORD_W),
        .FUSE_FRAMES(FUSE_FRAMES),
        .EXP_FRAMES (EXP_FRAMES)
    ) u_bomb1 (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .i_play (w_play),
        .i_title(w_title),
        .i_tick (frame_tick),
        .i_req  (w_req1),
        .i_px   (p1_x),
        .i_py   (p1_y),
        .o_bx   (b1_x),
        .o_by   (b1_y),
        .o_phase(b1_phase)
    );

    bomb_fsm #(
        .COORD_W    (COORD_W),
        .FUSE_FRAMES(FUSE_FRAMES),
        .EXP_FRAMES (EXP_FRAMES)
    ) u_bomb2 (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .i_play (w_play),
        .i_title(w_title),
        .i_tick (frame_tick),
        .i_req  (w_req2),
        .i_px   (p2_x),
        .i_py   (p2_y),
        .o_bx   (b2_x),
        .o_by   (b2_y),
        .o_phase(b2_phase)
    );

    assign w_hit1 = f_covered(p1_x, p1_y, b1_x, b1_y, b1_phase) ||
                    f_covered(p1_x, p1_y, b2_x, b2_y, b2_phase);
    assign w_hit2 = f_covered(p2_x, p2_y, b1_x, b1_y, b1_phase) ||
                    f_covered(p2_x, p2_y, b2_x, b2_y, b2_phase);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_prev_key <= '0;
            r_p1die    <= 1'b0;
            r_p2die    <= 1'b0;
        end else begin
            // Edge history tracks the key in every mode, so a key held across a
            // pause does not re-place on resume.
            r_prev_key <= keycode;
            if (w_title) begin
                r_p1die <= 1'b0;
                r_p2die <= 1'b0;
            end else if (w_play) begin
                if (w_hit1) r_p1die <= 1'b1;
                if (w_hit2) r_p2die <= 1'b1;
            end
        end
    end

    assign p1die = r_p1die;
    assign p2die = r_p2die;

endmodule
